id_ex_reg: RTL

ID_EX_REG -- requirements
Module: id_ex_reg

---
 rtl/id_ex_reg_pkg.sv | 74 +++++++
 rtl/id_ex_reg_if.sv | 66 ++++++
 rtl/fwd_mux.sv | 39 +++
 rtl/id_ex_reg.sv | 104 ++++++++++
 4 files changed

// File: rtl/id_ex_reg_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : id_ex_reg_pkg
//  Description : Shared MIPS definitions for the ID/EX pipeline register.
//                Holds the ALU function codes, the operand forward-select
//                encoding, the packed ID/EX payload and the forward priority
//                helper used by fwd_mux.
//  Revision    : 1.0 - initial release
// ============================================================================
package id_ex_reg_pkg;

    // ALU function codes
    localparam logic [5:0] ALU_ADD = 6'b000000;
    localparam logic [5:0] ALU_SUB = 6'b000001;
    localparam logic [5:0] ALU_AND = 6'b011000;
    localparam logic [5:0] ALU_OR  = 6'b011110;
    localparam logic [5:0] ALU_XOR = 6'b010110;
    localparam logic [5:0] ALU_SLL = 6'b100000;
    localparam logic [5:0] ALU_SRL = 6'b100001;
    localparam logic [5:0] ALU_SRA = 6'b100011;
    // A bubble carries the all-zero function code
    localparam logic [5:0] ALU_BUBBLE = 6'b000000;

    // Operand source select: register file, EX/MEM result or MEM/WB data
    typedef enum logic [1:0] {
        FWD_RF    = 2'b00,
        FWD_EXMEM = 2'b01,
        FWD_MEMWB = 2'b10
    } fwd_sel_e;

    // Everything the ID/EX register stores
    typedef struct packed {
        logic        valid;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [31:0] rs_data;
        logic [31:0] rt_data;
        logic [31:0] imm;
        logic [4:0]  shamt;
        logic        alu_src_a;
        logic        alu_src_b;
        logic [5:0]  alu_fun;
        logic        sign;
        logic        reg_write;
        logic        mem_read;
        logic        mem_write;
        logic [4:0]  wr_addr;
    } id_ex_t;

    // All-zero payload: invalid, no side effects, zero data and register numbers
    localparam id_ex_t ID_EX_BUBBLE = '0;

    // EX/MEM wins over MEM/WB; register 0 is never forwarded.
    function automatic fwd_sel_e fwd_select(
        input logic [4:0] src,
        input logic       ex_rw,
        input logic [4:0] ex_addr,
        input logic       wb_rw,
        input logic [4:0] wb_addr
    );
        fwd_sel_e sel;
        sel = FWD_RF;
        if (src != 5'd0) begin
            if (ex_rw && (ex_addr == src)) begin
                sel = FWD_EXMEM;
            end else if (wb_rw && (wb_addr == src)) begin
                sel = FWD_MEMWB;
            end
        end
        return sel;
    endfunction

endpackage
`default_nettype wire

// File: rtl/id_ex_reg_if.sv
`default_nettype none
// ============================================================================
//  Module      : id_ex_reg_if
//  Description : Bundle between decode / later stages and the ID/EX register.
//                Inputs : decode instruction fields, flush, EX/MEM and MEM/WB
//                         write-back info.
//                Outputs: oStall, registered control and forwarded operands.
//                slave  = the ID/EX register, master = surrounding pipeline.
//  Revision    : 1.0 - initial release
// ============================================================================
interface id_ex_reg_if;
    logic        iValid;
    logic [4:0]  iRs;
    logic [4:0]  iRt;
    logic        iUseRs;
    logic        iUseRt;
    logic [31:0] iRsData;
    logic [31:0] iRtData;
    logic [31:0] iImm;
    logic [4:0]  iShamt;
    logic        iALUSrcA;
    logic        iALUSrcB;
    logic [5:0]  iALUFun;
    logic        iSign;
    logic        iRegWrite;
    logic        iMemRead;
    logic        iMemWrite;
    logic [4:0]  iWrAddr;
    logic        iFlush;
    logic        iExMemRegWrite;
    logic [4:0]  iExMemWrAddr;
    logic [31:0] iExMemResult;
    logic        iMemWbRegWrite;
    logic [4:0]  iMemWbWrAddr;
    logic [31:0] iMemWbData;
    logic        oStall;
    logic        oValid;
    logic [31:0] oA;
    logic [31:0] oB;
    logic [5:0]  oALUFun;
    logic        oSign;
    logic [31:0] oStoreData;
    logic [4:0]  oWrAddr;
    logic        oRegWrite;
    logic        oMemRead;
    logic        oMemWrite;

    modport slave (
        input  iValid, iRs, iRt, iUseRs, iUseRt, iRsData, iRtData, iImm, iShamt,
               iALUSrcA, iALUSrcB, iALUFun, iSign, iRegWrite, iMemRead, iMemWrite,
               iWrAddr, iFlush, iExMemRegWrite, iExMemWrAddr, iExMemResult,
               iMemWbRegWrite, iMemWbWrAddr, iMemWbData,
        output oStall, oValid, oA, oB, oALUFun, oSign, oStoreData, oWrAddr,
               oRegWrite, oMemRead, oMemWrite
    );

    modport master (
        output iValid, iRs, iRt, iUseRs, iUseRt, iRsData, iRtData, iImm, iShamt,
               iALUSrcA, iALUSrcB, iALUFun, iSign, iRegWrite, iMemRead, iMemWrite,
               iWrAddr, iFlush, iExMemRegWrite, iExMemWrAddr, iExMemResult,
               iMemWbRegWrite, iMemWbWrAddr, iMemWbData,
        input  oStall, oValid, oA, oB, oALUFun, oSign, oStoreData, oWrAddr,
               oRegWrite, oMemRead, oMemWrite
    );
endinterface
`default_nettype wire

// File: rtl/fwd_mux.sv
`default_nettype none
// ============================================================================
//  Module      : fwd_mux
//  Description : 3:1 32-bit operand forwarding mux with priority select.
//                i_reg          registered source register number
//                i_rf_data      stored register-file read data
//                i_exmem_*      live EX/MEM write-back info (highest priority)
//                i_memwb_*      live MEM/WB write-back info
//                o_data         resolved operand value
//  Revision    : 1.0 - initial release
// ============================================================================
module fwd_mux
    import id_ex_reg_pkg::*;
(
    input  wire logic [4:0]  i_reg,
    input  wire logic [31:0] i_rf_data,
    input  wire logic        i_exmem_rw,
    input  wire logic [4:0]  i_exmem_addr,
    input  wire logic [31:0] i_exmem_data,
    input  wire logic        i_memwb_rw,
    input  wire logic [4:0]  i_memwb_addr,
    input  wire logic [31:0] i_memwb_data,
    output logic      [31:0] o_data
);

    fwd_sel_e w_sel;

    always_comb begin
        w_sel  = fwd_select(i_reg, i_exmem_rw, i_exmem_addr, i_memwb_rw, i_memwb_addr);
        o_data = i_rf_data;
        case (w_sel)
            FWD_EXMEM: o_data = i_exmem_data;
            FWD_MEMWB: o_data = i_memwb_data;
            default:   o_data = i_rf_data;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/id_ex_reg.sv
`default_nettype none
// ============================================================================
//  Module      : id_ex_reg
//  Description : ID/EX pipeline register with load-use stall detection,
//                bubble insertion on flush/stall and EX-stage operand
//                forwarding from EX/MEM and MEM/WB.
//                iClk    rising-edge clock
//                iRst_n  asynchronous active-low reset (loads a bubble)
//                bus     decode inputs, write-back info, stall and EX outputs
//  Revision    : 1.0 - initial release
// ============================================================================
module id_ex_reg
    import id_ex_reg_pkg::*;
(
    input  wire logic    iClk,
    input  wire logic    iRst_n,
    id_ex_reg_if.slave   bus
);

    id_ex_t      ex_d;
    id_ex_t      ex_q;
    logic        w_stall;
    logic        w_rs_hit;
    logic        w_rt_hit;
    logic [31:0] w_rs_fwd;
    logic [31:0] w_rt_fwd;

    // Load-use hazard: a load in EX writes a register the decode instruction reads.
    // Depends only on registered state for the EX side, so reset clears it at once.
    always_comb begin
        w_rs_hit = bus.iUseRs && (bus.iRs == ex_q.wr_addr);
        w_rt_hit = bus.iUseRt && (bus.iRt == ex_q.wr_addr);
        w_stall  = bus.iValid && ex_q.valid && ex_q.mem_read &&
                   (ex_q.wr_addr != 5'd0) && (w_rs_hit || w_rt_hit);
    end

    always_comb begin
        ex_d = ID_EX_BUBBLE;
        if (!(bus.iFlush || w_stall)) begin
            ex_d.valid     = bus.iValid;
            ex_d.rs        = bus.iRs;
            ex_d.rt        = bus.iRt;
            ex_d.rs_data   = bus.iRsData;
            ex_d.rt_data   = bus.iRtData;
            ex_d.imm       = bus.iImm;
            ex_d.shamt     = bus.iShamt;
            ex_d.alu_src_a = bus.iALUSrcA;
            ex_d.alu_src_b = bus.iALUSrcB;
            ex_d.alu_fun   = bus.iALUFun;
            ex_d.sign      = bus.iSign;
            ex_d.reg_write = bus.iRegWrite;
            ex_d.mem_read  = bus.iMemRead;
            ex_d.mem_write = bus.iMemWrite;
            ex_d.wr_addr   = bus.iWrAddr;
        end
    end

    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            ex_q <= ID_EX_BUBBLE;
        end else begin
            ex_q <= ex_d;
        end
    end

    // Forwarding uses the stored register numbers against the live write-back ports
    fwd_mux u_fwd_rs (
        .i_reg        (ex_q.rs),
        .i_rf_data    (ex_q.rs_data),
        .i_exmem_rw   (bus.iExMemRegWrite),
        .i_exmem_addr (bus.iExMemWrAddr),
        .i_exmem_data (bus.iExMemResult),
        .i_memwb_rw   (bus.iMemWbRegWrite),
        .i_memwb_addr (bus.iMemWbWrAddr),
        .i_memwb_data (bus.iMemWbData),
        .o_data       (w_rs_fwd)
    );

    fwd_mux u_fwd_rt (
        .i_reg        (ex_q.rt),
        .i_rf_data    (ex_q.rt_data),
        .i_exmem_rw   (bus.iExMemRegWrite),
        .i_exmem_addr (bus.iExMemWrAddr),
        .i_exmem_data (bus.iExMemResult),
        .i_memwb_rw   (bus.iMemWbRegWrite),
        .i_memwb_addr (bus.iMemWbWrAddr),
        .i_memwb_data (bus.iMemWbData),
        .o_data       (w_rt_fwd)
    );

    assign bus.oStall     = w_stall;
    assign bus.oValid     = ex_q.valid;
    assign bus.oA         = ex_q.alu_src_a ? {27'b0, ex_q.shamt} : w_rs_fwd;
    assign bus.oB         = ex_q.alu_src_b ? ex_q.imm : w_rt_fwd;
    assign bus.oStoreData = w_rt_fwd;
    assign bus.oALUFun    = ex_q.alu_fun;
    assign bus.oSign      = ex_q.sign;
    assign bus.oWrAddr    = ex_q.wr_addr;
    assign bus.oRegWrite  = ex_q.reg_write;
    assign bus.oMemRead   = ex_q.mem_read;
    assign bus.oMemWrite  = ex_q.mem_write;

endmodule
`default_nettype wire
